// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//
// Lets the instruction cache and the data cache share one physical-memory port
// (the cacheline adaptor). One cache is granted at a time. Its request is
// latched into transaction registers and held on the memory side until the
// adaptor responds. When both caches request together, the grant alternates
// round-robin so that neither cache can starve.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   i_pmem_read/write/address/wdata  I-cache request (level, held until resp)
//   i_pmem_rdata, i_pmem_resp        I-cache return line and completion pulse
//   d_pmem_*                         the same set for the D-cache
//   mem_read/write/address/wdata     request to the cacheline adaptor
//   mem_rdata, mem_resp              adaptor return line and completion pulse
//   grant_i_count, grant_d_count     completed transactions per cache
//   conflict_count                   IDLE cycles in which both caches requested
// ----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    output logic [31:0]       grant_i_count,
    output logic [31:0]       grant_d_count,
    output logic [31:0]       conflict_count
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
    typedef enum logic       {GRANT_I, GRANT_D}        grant_e;

    // Byte offset within a line; these address bits never reach memory.
    localparam logic [ADDR_W-1:0] LINE_OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    state_e              state_q;
    grant_e              last_grant_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [31:0]         grant_i_count_q;
    logic [31:0]         grant_d_count_q;
    logic [31:0]         conflict_count_q;

    // Arbitration decision, only acted upon in IDLE.
    logic                req_i_d;
    logic                req_d_d;
    logic                conflict_d;
    logic                pick_d_d;
    logic                sel_read_d;
    logic                sel_write_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [LINE_W-1:0]   sel_wdata_d;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), so no latch can be inferred.
    always_comb begin
        req_i_d     = i_pmem_read | i_pmem_write;
        req_d_d     = d_pmem_read | d_pmem_write;
        conflict_d  = req_i_d & req_d_d;
        // On a conflict the cache not granted last wins.
        pick_d_d    = req_d_d & (~req_i_d | (last_grant_q == GRANT_I));
        // Read and write together is illegal; the write is kept.
        sel_write_d = pick_d_d ? d_pmem_write : i_pmem_write;
        sel_read_d  = pick_d_d ? (d_pmem_read & ~d_pmem_write)
                               : (i_pmem_read & ~i_pmem_write);
        sel_addr_d  = (pick_d_d ? d_pmem_address : i_pmem_address) & ~LINE_OFF_MASK;
        sel_wdata_d = pick_d_d ? d_pmem_wdata : i_pmem_wdata;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            last_grant_q     <= GRANT_I;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            grant_i_count_q  <= '0;
            grant_d_count_q  <= '0;
            conflict_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A mem_resp seen here is spurious and falls through.
                    if (req_i_d | req_d_d) begin
                        state_q     <= pick_d_d ? SERVE_D : SERVE_I;
                        mem_read_q  <= sel_read_d;
                        mem_write_q <= sel_write_d;
                        addr_q      <= sel_addr_d;
                        wdata_q     <= sel_wdata_d;
                        if (conflict_d) begin
                            conflict_count_q <= conflict_count_q + 32'd1;
                        end
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        state_q         <= IDLE;
                        mem_read_q      <= 1'b0;
                        mem_write_q     <= 1'b0;
                        last_grant_q    <= GRANT_I;
                        grant_i_count_q <= grant_i_count_q + 32'd1;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        state_q         <= IDLE;
                        mem_read_q      <= 1'b0;
                        mem_write_q     <= 1'b0;
                        last_grant_q    <= GRANT_D;
                        grant_d_count_q <= grant_d_count_q + 32'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory side comes only from the transaction registers.
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_wdata      = wdata_q;

    // Zero-latency response path back to the granted cache.
    assign i_pmem_resp    = (state_q == SERVE_I) & mem_resp;
    assign d_pmem_resp    = (state_q == SERVE_D) & mem_resp;
    assign i_pmem_rdata   = mem_rdata;
    assign d_pmem_rdata   = mem_rdata;

    assign grant_i_count  = grant_i_count_q;
    assign grant_d_count  = grant_d_count_q;
    assign conflict_count = conflict_count_q;

endmodule
